// File: rtl/tt3_pkg.sv
// tt3_pkg: shared constants and state type for the tt3 truth-table sweeper.
// Holds vector count, index/counter widths, FSM encodings and a range helper.
package tt3_pkg;

  localparam int TT3_NVEC  = 8;
  localparam int TT3_IDX_W = 3;
  localparam int TT3_CNT_W = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRIVE = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    DRIVE = ST_DRIVE,
    DONE  = ST_DONE
  } tt3_state_t;

  function automatic bit tt3_settle_ok(input int s);
    return (s >= 1) && (s < (1 << TT3_CNT_W));
  endfunction

endpackage

// File: rtl/tt3_settle_cnt.sv
// tt3_settle_cnt: per-vector settle counter, counts 0..SETTLE-1 and wraps.
// Ports: clk, reset (async high), clr, en -> tc (count at SETTLE-1).
module tt3_settle_cnt
  import tt3_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [TT3_CNT_W-1:0] LAST =
    TT3_CNT_W'(SETTLE - 1);
  localparam logic [TT3_CNT_W-1:0] ONE =
    TT3_CNT_W'(1);

  logic [TT3_CNT_W-1:0] cnt;

  assign tc = (cnt == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tc ? '0 : cnt + ONE;
    end
  end

endmodule

// File: rtl/tt3_sweep_ctrl.sv
// tt3_sweep_ctrl: drives a/b/c through 0..7, samples y after SETTLE cycles,
// builds table_out. Ports: clk, reset, start, abort, exp_table, y in;
// a, b, c, busy, done, table_out, mismatch, err_mask out.
// Compare path (exp_table, err_mask, mismatch) needs TT3_COMPARE_EN.
module tt3_sweep_ctrl
  import tt3_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] exp_table,
  output logic       a,
  output logic       b,
  output logic       c,
  input  logic       y,
  output logic       busy,
  output logic       done,
  output logic [7:0] table_out,
  output logic       mismatch,
  output logic [7:0] err_mask
);

  localparam bit SETTLE_OK = tt3_settle_ok(SETTLE);

  localparam logic [TT3_IDX_W-1:0] IDX_LAST =
    TT3_IDX_W'(TT3_NVEC - 1);
  localparam logic [TT3_IDX_W-1:0] IDX_ONE =
    TT3_IDX_W'(1);

  tt3_state_t state_q;
  logic [TT3_IDX_W-1:0] idx_q;
  logic [TT3_NVEC-1:0]  shadow_q;
  logic [TT3_NVEC-1:0]  table_q;

  logic st_idle;
  logic st_drive;
  logic st_done;
  logic start_ok;
  logic abort_ok;
  logic cnt_clr;
  logic cnt_en;
  logic tc;

  assign st_idle  = (state_q == IDLE);
  assign st_drive = (state_q == DRIVE);
  assign st_done  = (state_q == DONE);

  assign start_ok = st_idle & start;
  assign abort_ok = st_drive & abort;

  assign cnt_clr = start_ok | abort_ok;
  assign cnt_en  = st_drive & ~abort;

  tt3_settle_cnt #(
    .SETTLE(SETTLE_OK ? SETTLE : 1)
  ) u_cnt (
    .clk  (clk),
    .reset(reset),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .tc   (tc)
  );

  // idx_q is forced to 0 outside DRIVE so a/b/c read 0 in IDLE and DONE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      shadow_q <= '0;
      table_q  <= '0;
    end else begin
      unique case (1'b1)
        st_idle: begin
          if (start) begin
            state_q  <= DRIVE;
            idx_q    <= '0;
            shadow_q <= '0;
          end
        end
        st_drive: begin
          if (abort) begin
            state_q <= IDLE;
            idx_q   <= '0;
          end else if (tc) begin
            shadow_q[idx_q] <= y;
            if (idx_q == IDX_LAST) begin
              state_q <= DONE;
              idx_q   <= '0;
            end else begin
              idx_q <= idx_q + IDX_ONE;
            end
          end
        end
        st_done: begin
          table_q <= shadow_q;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          idx_q   <= '0;
        end
      endcase
    end
  end

`ifdef TT3_COMPARE_EN
  logic [7:0] exp_q;
  logic [7:0] err_q;

  // err_mask uses the table captured with start, not the live input
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_q <= '0;
      err_q <= '0;
    end else begin
      if (start_ok) exp_q <= exp_table;
      if (st_done)  err_q <= shadow_q ^ exp_q;
    end
  end

  assign err_mask = err_q;
  assign mismatch = |err_q;
`else
  logic unused_exp;

  assign unused_exp = ^exp_table;
  assign err_mask   = '0;
  assign mismatch   = 1'b0;
`endif

  assign a = idx_q[2];
  assign b = idx_q[1];
  assign c = idx_q[0];

  assign busy      = ~st_idle;
  assign done      = st_done;
  assign table_out = table_q;

endmodule

// File: tb/tb_tt3_sweep_ctrl.sv
// tb_tt3_sweep_ctrl: randomized bench for tt3_sweep_ctrl at SETTLE 1 and 3.
// Each unit under sweep is a table-driven 3-input function that is wrong
// until its inputs have been stable for SETTLE cycles.
module tb_tt3_sweep_ctrl;

  localparam int SET [2] = '{1, 3};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] start = '0;
  logic [1:0] abort = '0;
  logic [7:0] exp_t [2];
  logic [7:0] fn_t  [2];
  logic [1:0] y;

  wire [1:0]  a;
  wire [1:0]  b;
  wire [1:0]  c;
  wire [1:0]  busy;
  wire [1:0]  done;
  wire [1:0]  mm;
  wire [15:0] tbl_w;
  wire [15:0] err_w;

  int checks = 0;
  int errors = 0;
  int stab [2];
  logic [2:0] prev [2];
  int dcnt [2];

  always #5 clk = ~clk;

  tt3_sweep_ctrl #(.SETTLE(1)) u_s1 (
    .clk(clk), .reset(rst),
    .start(start[0]), .abort(abort[0]),
    .exp_table(exp_t[0]),
    .a(a[0]), .b(b[0]), .c(c[0]), .y(y[0]),
    .busy(busy[0]), .done(done[0]),
    .table_out(tbl_w[7:0]),
    .mismatch(mm[0]), .err_mask(err_w[7:0])
  );

  tt3_sweep_ctrl #(.SETTLE(3)) u_s3 (
    .clk(clk), .reset(rst),
    .start(start[1]), .abort(abort[1]),
    .exp_table(exp_t[1]),
    .a(a[1]), .b(b[1]), .c(c[1]), .y(y[1]),
    .busy(busy[1]), .done(done[1]),
    .table_out(tbl_w[15:8]),
    .mismatch(mm[1]), .err_mask(err_w[15:8])
  );

  function automatic logic [2:0] abc(input int k);
    return {a[k], b[k], c[k]};
  endfunction

  function automatic logic [7:0] tbl(input int k);
    return tbl_w[k*8 +: 8];
  endfunction

  function automatic logic [7:0] errm(input int k);
    return err_w[k*8 +: 8];
  endfunction

  function automatic logic [7:0] exp_err(
    input logic [7:0] fn, input logic [7:0] ev);
`ifdef TT3_COMPARE_EN
    return fn ^ ev;
`else
    return 8'h00 & (fn ^ ev);
`endif
  endfunction

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (abc(k) != prev[k]) stab[k] <= 0;
      else if (stab[k] < 1000) stab[k] <= stab[k] + 1;
      prev[k] <= abc(k);
    end
  end

  always_comb begin
    y = '0;
    for (int k = 0; k < 2; k++) begin
      if (stab[k] >= SET[k] - 1) y[k] = fn_t[k][abc(k)];
      else y[k] = ~fn_t[k][abc(k)];
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++)
      if (done[k]) dcnt[k] = dcnt[k] + 1;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic run_sweep(input int k,
                           input logic [7:0] fn,
                           input logic [7:0] ev);
    int m;
    int nbad;
    int d0;
    int q[$];
    fn_t[k] = fn;
    exp_t[k] = ev;
    d0 = dcnt[k];
    start[k] = 1'b1;
    m = 0;
    while (m < 200) begin
      @(negedge clk);
      m++;
      start[k] = 1'b0;
      exp_t[k] = 8'($urandom);
      if (done[k]) break;
      if (busy[k]) q.push_back(int'(abc(k)));
    end
    chk($sformatf("lat%0d", k), m, 8 * SET[k] + 1);
    nbad = 0;
    if (q.size() != 8 * SET[k]) nbad = 1000;
    else
      for (int i = 0; i < q.size(); i++)
        if (q[i] != i / SET[k]) nbad++;
    chk($sformatf("seq%0d", k), nbad, 0);
    @(negedge clk);
    chk($sformatf("tbl%0d", k), tbl(k), fn);
    chk($sformatf("err%0d", k), errm(k), exp_err(fn, ev));
    chk($sformatf("mm%0d", k), mm[k], |exp_err(fn, ev));
    chk($sformatf("idle%0d", k), busy[k], 0);
    chk($sformatf("ndone%0d", k), dcnt[k] - d0, 1);
  endtask

  initial begin
    int m;
    int d0;
    logic [7:0] e0;
    logic [7:0] fn;
    for (int k = 0; k < 2; k++) begin
      exp_t[k] = '0; fn_t[k] = '0;
      stab[k] = 0; prev[k] = '0; dcnt[k] = 0;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_tbl", tbl(k), 0);
      chk("rst_err", errm(k), 0);
      chk("rst_sig", {busy[k], done[k], mm[k], abc(k)}, 0);
    end
    rst = 1'b0;
    @(negedge clk);

    run_sweep(0, 8'h31, 8'h31);
    run_sweep(0, 8'h31, 8'h30);
    run_sweep(1, 8'h31, 8'h31);

    // abort at index 4 on the SETTLE=1 unit
    e0 = errm(0);
    d0 = dcnt[0];
    fn_t[0] = 8'hCE;
    start[0] = 1'b1;
    m = 0;
    while (m < 50) begin
      @(negedge clk);
      m++;
      start[0] = 1'b0;
      if (abc(0) == 3'd4) break;
    end
    chk("ab_reach", abc(0), 3'd4);
    abort[0] = 1'b1;
    @(negedge clk);
    abort[0] = 1'b0;
    chk("ab_busy", busy[0], 0);
    chk("ab_abc", abc(0), 0);
    repeat (12) @(negedge clk);
    chk("ab_ndone", dcnt[0] - d0, 0);
    chk("ab_tbl", tbl(0), 8'h31);
    chk("ab_err", errm(0), e0);

    // start ignored while busy and in DONE, accepted right after
    d0 = dcnt[1];
    fn_t[1] = 8'h5A;
    exp_t[1] = 8'h5A;
    start[1] = 1'b1;
    @(negedge clk);
    start[1] = 1'b0;
    repeat (4) @(negedge clk);
    start[1] = 1'b1;
    @(negedge clk);
    start[1] = 1'b0;
    m = 0;
    while (m < 100 && !done[1]) begin
      @(negedge clk);
      m++;
    end
    chk("ig_done", done[1], 1);
    start[1] = 1'b1;
    @(negedge clk);
    chk("ig_idle", busy[1], 0);
    chk("ig_ndone", dcnt[1] - d0, 1);
    chk("ig_tbl", tbl(1), 8'h5A);
    @(negedge clk);
    start[1] = 1'b0;
    chk("b2b_busy", busy[1], 1);
    m = 0;
    while (m < 100 && !done[1]) begin
      @(negedge clk);
      m++;
    end
    @(negedge clk);
    chk("b2b_ndone", dcnt[1] - d0, 2);

    // start and abort together in IDLE: start wins
    fn_t[0] = 8'h96;
    exp_t[0] = 8'h96;
    start[0] = 1'b1;
    abort[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    abort[0] = 1'b0;
    chk("sa_busy", busy[0], 1);
    m = 0;
    while (m < 50 && !done[0]) begin
      @(negedge clk);
      m++;
    end
    @(negedge clk);
    chk("sa_tbl", tbl(0), 8'h96);

    // asynchronous reset in the middle of a DRIVE cycle
    fn_t[1] = 8'hA5;
    start[1] = 1'b1;
    @(negedge clk);
    start[1] = 1'b0;
    repeat (6) @(negedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_abc", abc(1), 0);
    chk("ar_busy", busy, 0);
    chk("ar_tbl", tbl_w, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_sweep(1, 8'h3C, 8'h3D);

    for (int i = 0; i < 8; i++) begin
      fn = 8'($urandom);
      run_sweep(int'($urandom_range(0, 1)), fn, 8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
